// File: rtl/adder_arbiter.sv
// Shares one clocked adder among NREQ requesters: arbitrate, issue for one cycle, return tagged result.
// Define ADDER_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module adder_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 4,
  parameter int IDW   = 2
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic [NREQ-1:0]       Req,
  input  logic [NREQ*WIDTH-1:0] ReqA,
  input  logic [NREQ*WIDTH-1:0] ReqB,
  output logic [NREQ-1:0]       Gnt,
  output logic                  RespValid,
  output logic [IDW-1:0]        RespId,
  output logic [WIDTH-1:0]      RespSum,
  output logic                  RespOverflow,
  output logic [WIDTH-1:0]      AddA,
  output logic [WIDTH-1:0]      AddB,
  output logic                  AddEn,
  input  logic [WIDTH-1:0]      AddSum,
  input  logic                  AddOverflow
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d, opb_q, opb_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [IDW-1:0]   resp_id_q;
  logic [WIDTH-1:0] resp_sum_q;
  logic             resp_ovf_q;

  logic             win_found;
  logic [IDW-1:0]   win_id;
  logic [NREQ-1:0]  win_onehot;
  logic [WIDTH-1:0] win_a, win_b;
  logic [WIDTH-1:0] req_a [NREQ];
  logic [WIDTH-1:0] req_b [NREQ];

`ifndef ADDER_ARB_FIXED_PRIO_EN
  logic [IDW-1:0]   ptr_q, ptr_d;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign req_a[gi] = ReqA[gi*WIDTH +: WIDTH];
      assign req_b[gi] = ReqB[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // Scan from the start index with wrap; the first set request wins.
  always_comb begin : arbitrate
    int start_idx;
    int idx;
    win_found  = 1'b0;
    win_id     = '0;
    win_onehot = '0;
    win_a      = '0;
    win_b      = '0;
    idx        = 0;
`ifdef ADDER_ARB_FIXED_PRIO_EN
    start_idx  = 0;
`else
    start_idx  = int'(ptr_q);
`endif
    for (int k = 0; k < NREQ; k++) begin
      idx = (start_idx + k) % NREQ;
      if (!win_found && Req[idx]) begin
        win_found       = 1'b1;
        win_id          = IDW'(idx);
        win_onehot[idx] = 1'b1;
        win_a           = req_a[idx];
        win_b           = req_b[idx];
      end
    end
  end

  always_comb begin : fsm_next
    state_d   = state_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    id_d      = id_q;
    Gnt       = '0;
    AddEn     = 1'b0;
    RespValid = 1'b0;
`ifndef ADDER_ARB_FIXED_PRIO_EN
    ptr_d     = ptr_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (win_found && !Reset) begin
          Gnt     = win_onehot;
          opa_d   = win_a;
          opb_d   = win_b;
          id_d    = win_id;
          state_d = ISSUE;
`ifndef ADDER_ARB_FIXED_PRIO_EN
          ptr_d   = (win_id == IDW'(NREQ - 1)) ? '0 : win_id + 1'b1;
`endif
        end
      end
      ISSUE: begin
        AddEn   = 1'b1;
        state_d = CAPTURE;
      end
      CAPTURE: begin
        RespValid = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= IDLE;
      opa_q      <= '0;
      opb_q      <= '0;
      id_q       <= '0;
      resp_id_q  <= '0;
      resp_sum_q <= '0;
      resp_ovf_q <= 1'b0;
`ifndef ADDER_ARB_FIXED_PRIO_EN
      ptr_q      <= '0;
`endif
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      id_q    <= id_d;
`ifndef ADDER_ARB_FIXED_PRIO_EN
      ptr_q   <= ptr_d;
`endif
      if (state_q == CAPTURE) begin
        resp_id_q  <= id_q;
        resp_sum_q <= AddSum;
        resp_ovf_q <= AddOverflow;
      end
    end
  end

  // Result is live during CAPTURE and held afterwards.
  assign RespId       = (state_q == CAPTURE) ? id_q        : resp_id_q;
  assign RespSum      = (state_q == CAPTURE) ? AddSum      : resp_sum_q;
  assign RespOverflow = (state_q == CAPTURE) ? AddOverflow : resp_ovf_q;
  assign AddA         = opa_q;
  assign AddB         = opb_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed bench for adder_arbiter with a behavioural clocked adder attached.
module tb_adder_arbiter;

  logic        clk = 1'b0;
  logic        Reset;
  logic [3:0]  Req;
  logic [15:0] ReqA, ReqB;
  logic [3:0]  Gnt;
  logic        RespValid;
  logic [1:0]  RespId;
  logic [3:0]  RespSum;
  logic        RespOverflow;
  logic [3:0]  AddA, AddB;
  logic        AddEn;
  logic [3:0]  AddSum = '0;
  logic        AddOverflow = 1'b0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Clocked adder: result updates on the edge where En is high, then holds.
  always @(posedge clk) begin
    if (AddEn) {AddOverflow, AddSum} <= {1'b0, AddA} + {1'b0, AddB};
  end

  adder_arbiter #(.NREQ(4), .WIDTH(4), .IDW(2)) dut (
    .Clk(clk), .Reset(Reset), .Req(Req), .ReqA(ReqA), .ReqB(ReqB),
    .Gnt(Gnt), .RespValid(RespValid), .RespId(RespId), .RespSum(RespSum),
    .RespOverflow(RespOverflow), .AddA(AddA), .AddB(AddB), .AddEn(AddEn),
    .AddSum(AddSum), .AddOverflow(AddOverflow)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One full operation: grant cycle, issue cycle, capture cycle.
  task automatic run_op(input string tag, input logic [3:0] req_v,
                        input logic [15:0] a_v, input logic [15:0] b_v,
                        input logic [3:0] exp_gnt, input logic [1:0] exp_id,
                        input logic [3:0] exp_sum, input logic exp_ovf,
                        input logic [3:0] req_after);
    @(negedge clk);
    Req = req_v; ReqA = a_v; ReqB = b_v;
    #1;
    chk({tag, ".gnt"}, Gnt, exp_gnt);
    chk({tag, ".en_grant"}, AddEn, 1'b0);
    @(negedge clk);
    Req = req_after; ReqA = ~a_v; ReqB = ~b_v;
    #1;
    chk({tag, ".add_en"}, AddEn, 1'b1);
    chk({tag, ".add_a"}, AddA, a_v[exp_id*4 +: 4]);
    chk({tag, ".add_b"}, AddB, b_v[exp_id*4 +: 4]);
    chk({tag, ".gnt_issue"}, Gnt, 4'b0000);
    @(negedge clk);
    #1;
    chk({tag, ".valid"}, RespValid, 1'b1);
    chk({tag, ".id"}, RespId, exp_id);
    chk({tag, ".sum"}, RespSum, exp_sum);
    chk({tag, ".ovf"}, RespOverflow, exp_ovf);
    chk({tag, ".en_capture"}, AddEn, 1'b0);
    $display("op %s: gnt=%b id=%0d sum=%0d ovf=%0b", tag, exp_gnt, RespId, RespSum, RespOverflow);
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    Reset = 1'b1;
    #1;
    Reset = 1'b0;
  endtask

  typedef struct {
    logic [3:0]  req;
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  gnt;
    logic [1:0]  id;
    logic [3:0]  sum;
    logic        ovf;
  } vec_t;

  vec_t vecs [6];
  int   rr_ids [5];

  initial begin
    vecs[0] = '{4'b0001, 16'hEEE3, 16'hDDD4, 4'b0001, 2'd0, 4'd7,  1'b0};
    vecs[1] = '{4'b0100, 16'h3722, 16'h9199, 4'b0100, 2'd2, 4'd8,  1'b0};
    vecs[2] = '{4'b1000, 16'hF000, 16'h2FFF, 4'b1000, 2'd3, 4'd1,  1'b1};
    vecs[3] = '{4'b0010, 16'h0090, 16'h0090, 4'b0010, 2'd1, 4'd2,  1'b1};
    vecs[4] = '{4'b0001, 16'h000F, 16'h0001, 4'b0001, 2'd0, 4'd0,  1'b1};
    vecs[5] = '{4'b0100, 16'h0800, 16'h0700, 4'b0100, 2'd2, 4'd15, 1'b0};
`ifdef ADDER_ARB_FIXED_PRIO_EN
    rr_ids = '{0, 0, 0, 0, 0};
`else
    rr_ids = '{0, 1, 2, 3, 0};
`endif

    // Reset state
    Reset = 1'b1; Req = '0; ReqA = '0; ReqB = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst.gnt", Gnt, 4'b0000);
    chk("rst.valid", RespValid, 1'b0);
    chk("rst.en", AddEn, 1'b0);
    chk("rst.resp", {RespId, RespSum, RespOverflow}, '0);
    chk("rst.add_ab", {AddA, AddB}, '0);
    @(negedge clk);
    Reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      chk("idle.en", AddEn, 1'b0);
      chk("idle.gnt", Gnt, 4'b0000);
      chk("idle.valid", RespValid, 1'b0);
    end

    // Single-requester vectors, each followed by a hold check
    for (int v = 0; v < 6; v++) begin
      run_op($sformatf("vec%0d", v), vecs[v].req, vecs[v].a, vecs[v].b,
             vecs[v].gnt, vecs[v].id, vecs[v].sum, vecs[v].ovf, 4'b0000);
      @(negedge clk);
      #1;
      chk("hold.valid", RespValid, 1'b0);
      chk("hold.sum", RespSum, vecs[v].sum);
      chk("hold.id", RespId, vecs[v].id);
      chk("hold.gnt", Gnt, 4'b0000);
    end

    // All requesters held: grant order and 3-cycle cadence
    reset_pulse();
    for (int g = 0; g < 5; g++) begin
      run_op($sformatf("all%0d", g), 4'b1111, 16'h4321, 16'h4321,
             4'(1 << rr_ids[g]), 2'(rr_ids[g]), 4'(2 * (rr_ids[g] + 1)), 1'b0,
             (g == 4) ? 4'b0000 : 4'b1111);
    end

    // Reset during ISSUE: operation dropped, pointer back to 0
    @(negedge clk);
    Req = 4'b0010; ReqA = 16'h0050; ReqB = 16'h0030;
    #1;
    chk("midrst.gnt", Gnt, 4'b0010);
    @(negedge clk);
    Req = 4'b0000;
    #1;
    chk("midrst.issue", AddEn, 1'b1);
    Reset = 1'b1;
    #1;
    chk("midrst.en_cleared", AddEn, 1'b0);
    chk("midrst.sum_cleared", RespSum, 4'd0);
    Reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #1;
      chk("midrst.no_valid", RespValid, 1'b0);
    end
    run_op("post_rst", 4'b0110, 16'h0A30, 16'h0140, 4'b0010, 2'd1, 4'd7, 1'b0, 4'b0000);

    // Pointer at 3 after granting id 2, then wrap
    run_op("ptr_to3", 4'b0100, 16'h0600, 16'h0600, 4'b0100, 2'd2, 4'd12, 1'b0, 4'b0000);
`ifdef ADDER_ARB_FIXED_PRIO_EN
    run_op("wrap_a", 4'b1001, 16'h8001, 16'h9002, 4'b0001, 2'd0, 4'd3, 1'b0, 4'b1001);
`else
    run_op("wrap_a", 4'b1001, 16'h8001, 16'h9002, 4'b1000, 2'd3, 4'd1, 1'b1, 4'b1001);
`endif
    run_op("wrap_b", 4'b1001, 16'h8001, 16'h9002, 4'b0001, 2'd0, 4'd3, 1'b0, 4'b0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
